// File: rtl/mul_iter_pkg.sv
// Shared core definitions for the RV32M iterative multiplier:
// operand width, M-extension funct3 codes and the iterative-unit state enum.
package mul_iter_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned PW    = 2 * XLEN;
   localparam int unsigned CNT_W = $clog2(XLEN);

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;
   localparam logic [2:0] F_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } iter_state_e;

   // Magnitude of an operand; 0x80000000 maps to 2^31 as an unsigned value.
   function automatic logic [XLEN-1:0] op_mag(input logic [XLEN-1:0] v, input logic is_signed);
      return (is_signed && v[XLEN-1]) ? XLEN'(~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/mul_iter_if.sv
// Request/result handshake bundle between EX and the iterative multiplier.
interface mul_iter_if;
   import mul_iter_pkg::*;

   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1_value;
   logic [XLEN-1:0] rs2_value;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] mul_out;

   modport master (
      output flush, in_valid, funct3, rs1_value, rs2_value, out_ready,
      input  in_ready, out_valid, mul_out
   );

   modport slave (
      input  flush, in_valid, funct3, rs1_value, rs2_value, out_ready,
      output in_ready, out_valid, mul_out
   );

endinterface

// File: rtl/mul_iter.sv
// Radix-2 shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU), fixed 33-edge
// latency from accept to result, valid/ready on both sides, flush abort.
module mul_iter
   import mul_iter_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   mul_iter_if.slave  bus
);

   iter_state_e      r_state;
   iter_state_e      w_state_nxt;
   logic             w_out_valid_nxt;
   logic             w_accept;

   logic [CNT_W-1:0] r_cnt;
   logic [PW-1:0]    r_acc;
   logic [PW-1:0]    r_mcand;
   logic [XLEN-1:0]  r_mplier;
   logic [XLEN-1:0]  r_mul_out;
   logic             r_neg;
   logic             r_hi;
   logic             r_out_valid;

   logic [2:0]       w_f3;
   logic             w_s1;
   logic             w_s2;
   logic             w_last_iter;
   logic [PW-1:0]    w_prod;

   // Illegal 1xx codes fold onto MUL before signedness is decided.
   assign w_f3        = bus.funct3[2] ? F_MUL : bus.funct3;
   assign w_s1        = (w_f3 == F_MULH) || (w_f3 == F_MULHSU);
   assign w_s2        = (w_f3 == F_MULH);
   assign w_last_iter = (r_cnt == CNT_W'(XLEN - 1));
   assign w_prod      = r_neg ? (~r_acc + PW'(1)) : r_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_out_valid <= w_out_valid_nxt;
      end
   end

   // Next-state logic; flush overrides everything outside IDLE and blocks accept in IDLE.
   always_comb begin
      w_state_nxt     = r_state;
      w_accept        = 1'b0;
      w_out_valid_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.in_valid && !bus.flush) begin
               w_accept    = 1'b1;
               w_state_nxt = CALC;
            end
         end
         CALC: begin
            if (bus.flush)        w_state_nxt = IDLE;
            else if (w_last_iter) w_state_nxt = FIX;
         end
         FIX: begin
            w_state_nxt = bus.flush ? IDLE : DONE;
         end
         DONE: begin
            if (bus.flush || bus.out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      w_out_valid_nxt = (w_state_nxt == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_acc     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_neg     <= 1'b0;
         r_hi      <= 1'b0;
         r_mul_out <= '0;
      end else begin
         if (w_accept) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {XLEN'(0), op_mag(bus.rs1_value, w_s1)};
            r_mplier <= op_mag(bus.rs2_value, w_s2);
            r_neg    <= (w_s1 & bus.rs1_value[XLEN-1]) ^ (w_s2 & bus.rs2_value[XLEN-1]);
            r_hi     <= (w_f3 != F_MUL);
         end else if (r_state == CALC && !bus.flush) begin
            // One multiplier bit per edge, LSB first.
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
         end
         if (r_state == FIX && !bus.flush) begin
            r_mul_out <= r_hi ? w_prod[PW-1:XLEN] : w_prod[XLEN-1:0];
         end
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = r_out_valid;
   assign bus.mul_out   = r_mul_out;

endmodule
